// File: rtl/dcache_ctrl.sv
// Main sequencing FSM of the 2-way set-associative write-back data cache.
// Steps each CPU access through lookup, hit completion, victim writeback,
// line refill and replay lookup, and drives the replacement-tracker strobes.
module dcache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_W     = 2,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  output logic              req_latch,
  output logic              cpu_done,
  input  logic              hit1,
  input  logic              hit2,
  input  logic              way_sel,
  input  logic              victim_dirty,
  output logic              lru_update,
  output logic              lru_change,
  output logic              hit_way,
  output logic              data_we,
  output logic              victim_way,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              mem_wr_req,
  input  logic              mem_wr_ack,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  output logic              refill_we,
  output logic              tag_we,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, REFILL
  } state_t;

  state_t state, state_nxt;
  logic   replay;     // set by REFILL so the replay hit is not counted as a hit
  logic   we_q;       // store/load flag captured with the request
  logic   hit;
  logic   last_beat;

  assign hit       = hit1 | hit2;
  assign last_beat = (beat_cnt == BEAT_W'(LINE_WORDS - 1));

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    sat_inc = (&v) ? v : v + PERF_W'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and combinational strobes.
  always_comb begin
    state_nxt    = state;
    req_latch    = 1'b0;
    cpu_done     = 1'b0;
    lru_update   = 1'b0;
    lru_change   = 1'b0;
    hit_way      = 1'b0;
    data_we      = 1'b0;
    mem_wr_req   = 1'b0;
    mem_wr_valid = 1'b0;
    mem_rd_req   = 1'b0;
    refill_we    = 1'b0;
    tag_we       = 1'b0;
    unique case (state)
      IDLE: begin
        req_latch = cpu_req;
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_done   = 1'b1;
          lru_update = 1'b1;
          hit_way    = hit2;
          data_we    = we_q;
          state_nxt  = IDLE;
        end else if (victim_dirty) begin
          state_nxt = WB_REQ;
        end else begin
          state_nxt = RF_REQ;
        end
      end
      WB_REQ: begin
        mem_wr_req = 1'b1;
        if (mem_wr_ack) state_nxt = WB_DATA;
      end
      WB_DATA: begin
        mem_wr_valid = 1'b1;
        if (mem_wr_ready && last_beat) state_nxt = RF_REQ;
      end
      RF_REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_nxt = RF_DATA;
      end
      RF_DATA: begin
        refill_we = mem_rd_valid;
        if (mem_rd_valid && last_beat) state_nxt = REFILL;
      end
      REFILL: begin
        tag_we     = 1'b1;
        lru_change = 1'b1;
        state_nxt  = LOOKUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter, victim way, replay flag and performance counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt   <= '0;
      victim_way <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      replay     <= 1'b0;
    end else begin
      unique case (state)
        LOOKUP: begin
          if (hit) begin
            if (!replay) hit_cnt <= sat_inc(hit_cnt);
            replay <= 1'b0;
          end else begin
            miss_cnt   <= sat_inc(miss_cnt);
            victim_way <= way_sel;
            beat_cnt   <= '0;
          end
        end
        WB_DATA: if (mem_wr_ready) beat_cnt <= beat_cnt + BEAT_W'(1);
        RF_DATA: if (mem_rd_valid) beat_cnt <= beat_cnt + BEAT_W'(1);
        REFILL:  replay <= 1'b1;
        default: ;
      endcase
    end
  end

  // Store/load flag captured alongside the external request latch.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) we_q <= cpu_we;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: drives accesses with a small bus and tag
// responder, queues the expected completion of each access and checks it when
// cpu_done appears, plus per-beat and counter checks along the way.
module tb_dcache_ctrl;
  localparam int LW = 4;
  localparam int BW = 2;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we, req_latch, cpu_done;
  logic          hit1, hit2, way_sel, victim_dirty;
  logic          lru_update, lru_change, hit_way, data_we, victim_way;
  logic [BW-1:0] beat_cnt;
  logic          mem_wr_req, mem_wr_ack, mem_wr_valid, mem_wr_ready;
  logic          mem_rd_req, mem_rd_ack, mem_rd_valid;
  logic          refill_we, tag_we;
  logic [PW-1:0] hit_cnt, miss_cnt;

  dcache_ctrl #(.LINE_WORDS(LW), .BEAT_W(BW), .PERF_W(PW)) dut (
    .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .req_latch(req_latch), .cpu_done(cpu_done), .hit1(hit1), .hit2(hit2),
    .way_sel(way_sel), .victim_dirty(victim_dirty), .lru_update(lru_update),
    .lru_change(lru_change), .hit_way(hit_way), .data_we(data_we),
    .victim_way(victim_way), .beat_cnt(beat_cnt), .mem_wr_req(mem_wr_req),
    .mem_wr_ack(mem_wr_ack), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .mem_rd_req(mem_rd_req),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid),
    .refill_we(refill_we), .tag_we(tag_we), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   lat;
    logic hw;
    logic dwe;
    int   rdreq;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   m_hit      = 0;
  int   m_miss     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {22'd0, req_latch, cpu_done, lru_update, lru_change, data_we,
                           mem_wr_req, mem_wr_valid, mem_rd_req, refill_we, tag_we}, 32'd0);
    chk({tag, "_beat"}, beat_cnt, 0);
    chk({tag, "_vway"}, victim_way, 0);
    chk({tag, "_hitcnt"}, hit_cnt, 0);
    chk({tag, "_misscnt"}, miss_cnt, 0);
  endtask

  // One CPU access from request to completion. abort_beat >= 0 pulls rstn
  // low while that refill beat is being written and abandons the access.
  task automatic access(input logic we, input logic h1, input logic h2,
                        input logic ws, input logic vd, input int wr_tog,
                        input int rd_gap, input int lat, input int rdreq,
                        input int abort_beat);
    exp_t e, got;
    int   first_rd = -1, rf_beat = 0, wb_beat = 0, lat_o = -1;
    bit   done = 0, tog = 0, pend_hit = 0;
    logic hw_o = 1'bx, dwe_o = 1'bx;
    e.lat = lat; e.hw = h2 ? 1'b1 : (h1 ? 1'b0 : ws); e.dwe = we; e.rdreq = rdreq;
    sb.push_back(e);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; hit1 = h1; hit2 = h2; way_sel = ws;
    victim_dirty = vd; mem_wr_ack = 1'b1; mem_rd_ack = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (pend_hit) begin
        hit1 = (ws == 1'b0); hit2 = (ws == 1'b1); pend_hit = 0;
      end
      if (mem_wr_valid) begin
        mem_wr_ready = (wr_tog == 0) || !tog;
        tog = !tog;
      end else begin
        mem_wr_ready = 1'b1;
      end
      mem_rd_valid = (rd_gap == 0) || (cyc % 3 != 0);
      @(negedge clk);
      chk("lru_excl", {31'd0, lru_update & lru_change}, 0);
      if (cyc == 0) chk("req_latch", req_latch, 1);
      if (mem_rd_req && first_rd < 0) first_rd = cyc;
      if (mem_wr_valid && mem_wr_ready) begin
        chk("wb_beat", beat_cnt, wb_beat);
        chk("wb_way", victim_way, ws);
        wb_beat++;
      end
      if (refill_we) begin
        if (abort_beat >= 0 && rf_beat == abort_beat) begin
          cpu_req = 1'b0;
          rstn = 1'b0;
          #1;
          chk_quiet("async_rst");
          void'(sb.pop_front());
          m_hit = 0; m_miss = 0;
          hit1 = 1'b0; hit2 = 1'b0;
          @(posedge clk); #1;
          chk_quiet("rst_held");
          rstn = 1'b1;
          return;
        end
        chk("rf_beat", beat_cnt, rf_beat);
        rf_beat++;
      end
      if (tag_we) begin
        chk("tag_after_refills", rf_beat, LW);
        chk("tag_way", victim_way, ws);
        chk("lru_change", lru_change, 1);
        chk("wb_beats", wb_beat, vd ? LW : 0);
        pend_hit = 1;
      end
      if (cpu_done) begin
        done = 1; lat_o = cyc; hw_o = hit_way; dwe_o = data_we;
        chk("lru_update", lru_update, 1);
      end else begin
        chk("data_we_quiet", data_we, 0);
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
    got = sb.pop_front();
    chk("latency", lat_o, got.lat);
    chk("hit_way", hw_o, got.hw);
    chk("data_we", dwe_o, got.dwe);
    if (got.rdreq >= 0) chk("rdreq_cycle", first_rd, got.rdreq);
    if (h1 | h2) m_hit++; else m_miss++;
    @(negedge clk);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    chk("idle_after", {30'd0, cpu_done, req_latch}, 0);
  endtask

  initial begin
    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
    way_sel = 1'b0; victim_dirty = 1'b0; mem_wr_ack = 1'b0; mem_wr_ready = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
    #12;
    chk_quiet("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // load hit way 0, store hit way 1, dual hit resolves to way 1
    access(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, -1, -1);
    access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1, -1);
    access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1, -1);
    // clean miss into way 1, zero-wait bus
    access(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 8, 2, -1);
    // dirty store miss, writeback ready toggling 1,0,1,0
    access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 16, 10, -1);
    // dirty miss, zero-wait bus
    access(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 13, 7, -1);
    // clean miss with refill data gaps
    access(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 10, 2, -1);
    // reset asserted during refill beat 2, then a normal hit
    access(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 8, 2, 2);
    access(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, -1, -1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Main sequencing FSM for the 2-way set-associative, write-back, write-allocate data cache (32 sets, 4-word lines).
- Per CPU access: sequences tag lookup, hit completion, victim writeback, line refill and replay.
- Drives the way-replacement tracker through its update/change strobes and consumes its way_sel.
- Sits between the CPU memory stage and the memory bus; tag/data arrays, address/wdata latches and data muxes are external and controlled by this block's strobes.

Parameters:
LINE_WORDS, 4, words per cache line (power of 2, >=2)
BEAT_W, 2, log2(LINE_WORDS); width of beat counter
PERF_W, 32, width of hit/miss performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
cpu_req  in  1  access request; held high by requester until cpu_done
cpu_we  in  1  1 = store, 0 = load; sampled with cpu_req in IDLE
req_latch  out  1  latch address/wdata/we into external request registers
cpu_done  out  1  one-cycle pulse: access complete (load data valid / store written)
hit1  in  1  way-0 tag match and valid, for latched address
hit2  in  1  way-1 tag match and valid, for latched address
way_sel  in  1  replacement victim way for latched index
victim_dirty  in  1  dirty bit of way way_sel at latched index
lru_update  out  1  hit strobe to replacement tracker
lru_change  out  1  replacement strobe to replacement tracker
hit_way  out  1  way hit in LOOKUP (hit2 has priority)
data_we  out  1  store-hit write of latched wdata into hit_way; sets dirty
victim_way  out  1  registered victim way for WB/refill/tag write
beat_cnt  out  BEAT_W  registered word index within line for WB/refill
mem_wr_req  out  1  writeback address request (line address of victim)
mem_wr_ack  in  1  writeback address accepted
mem_wr_valid  out  1  writeback word valid (word beat_cnt of victim_way)
mem_wr_ready  in  1  writeback word accepted
mem_rd_req  out  1  refill address request (line address of latched addr)
mem_rd_ack  in  1  refill address accepted
mem_rd_valid  in  1  refill word valid on bus
refill_we  out  1  write bus word into victim_way at beat_cnt
tag_we  out  1  write latched tag into victim_way; valid=1, dirty=0
hit_cnt  out  PERF_W  count of LOOKUP hits (first lookup only)
miss_cnt  out  PERF_W  count of misses

Behaviour:
- Reset (async, rstn low): state IDLE; beat_cnt=0, victim_way=0, hit_cnt=0, miss_cnt=0, replay flag=0; every strobe output 0. Any bus transaction in progress is abandoned.
- Strobe outputs are combinational from state and inputs. beat_cnt, victim_way and the counters are registered.
- lru_update and lru_change are never high in the same cycle.
- IDLE:
  - req_latch = cpu_req.
  - cpu_req=1 -> LOOKUP. Otherwise stay.
- LOOKUP (hit = hit1|hit2):
  - On hit: cpu_done=1, lru_update=1, hit_way=hit2. data_we=1 if latched we. Next state IDLE.
  - hit_cnt increments only when the replay flag is 0. Clear the replay flag.
  - On miss: miss_cnt+1; victim_way<=way_sel; beat_cnt<=0.
  - Miss with victim_dirty=1 -> WB_REQ; otherwise -> RF_REQ.
- WB_REQ: mem_wr_req=1 until mem_wr_ack, then -> WB_DATA.
- WB_DATA:
  - mem_wr_valid=1.
  - On mem_wr_ready: beat_cnt+1 (wraps to 0).
  - On the last beat (beat_cnt=LINE_WORDS-1) with ready -> RF_REQ.
- RF_REQ: mem_rd_req=1 until mem_rd_ack, then -> RF_DATA.
- RF_DATA:
  - refill_we=mem_rd_valid; beat_cnt+1 on valid.
  - Last beat with valid -> REFILL.
  - No valid: hold, no writes.
- REFILL: tag_we=1, lru_change=1, set replay flag -> LOOKUP. The replay must hit and completes the access.
- Both hit1 and hit2 asserted: treat as a way-1 hit; no error.
- cpu_req/cpu_we are not sampled outside IDLE; deassertion mid-miss does not abort.
- Counters saturate at all-ones.
- Latency, zero-wait bus:
  - Load/store hit: cpu_done 1 cycle after cpu_req is seen in IDLE.
  - Clean miss: cpu_done 8 cycles after cpu_req is seen in IDLE.
  - Dirty miss: cpu_done 8 cycles after cpu_req is seen in IDLE, plus 1+LINE_WORDS cycles for the writeback.

Test Plan:
- Load hit: reset, cpu_req=1 we=0, hit1=1 in LOOKUP -> cycle 1: cpu_done=1, lru_update=1, hit_way=0, data_we=0; hit_cnt=1.
- Store hit way 1: cpu_we=1, hit2=1 -> data_we=1, hit_way=1, cpu_done pulse; back in IDLE next cycle.
- Clean miss, acks immediate, mem_rd_valid every cycle, way_sel=1 ->
  - mem_rd_req at cycle 2; refill_we at cycles 3-6 with beat_cnt 0,1,2,3.
  - Cycle 7: tag_we=1, lru_change=1, victim_way=1.
  - Replay hit2 at cycle 8: cpu_done, lru_update; miss_cnt=1, hit_cnt=0.
- Dirty miss with mem_wr_ready toggling 1,0,1,0 -> exactly 4 accepted beats (0-3), no beat_cnt advance on ready=0, then RF_REQ and refill as above.
- Refill with mem_rd_valid gaps -> refill_we only on valid cycles; REFILL only after the 4th valid.
- rstn low during RF_DATA beat 2 -> all outputs 0, state IDLE, counters 0 immediately (async); new cpu_req after release runs a normal lookup.
